// File: rtl/fft_pkg.sv
// Shared constants, FSM state codes and bit-reverse helper for the FFT sequencer.
// Optional load phase is enabled by defining FFTSEQ_BITREV_LOAD_EN.
package fft_pkg;

  localparam int LOG2N_DEF = 7;
  localparam int N_DEF     = 1 << LOG2N_DEF;
  localparam int NH_DEF    = N_DEF / 2;
  localparam int BF_STEPS  = 9;

  typedef logic [3:0] state_t;

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] LD_RD = 4'd1;
  localparam logic [3:0] LD_WR = 4'd2;
  localparam logic [3:0] RDB   = 4'd3;
  localparam logic [3:0] MUL   = 4'd4;
  localparam logic [3:0] CADD  = 4'd5;
  localparam logic [3:0] RDA   = 4'd6;
  localparam logic [3:0] SUB   = 4'd7;
  localparam logic [3:0] WRB   = 4'd8;
  localparam logic [3:0] RDA2  = 4'd9;
  localparam logic [3:0] ADD   = 4'd10;
  localparam logic [3:0] WRA   = 4'd11;
  localparam logic [3:0] DONE  = 4'd12;

  function automatic logic [15:0] bitrev(
    input logic [15:0] v,
    input int          w
  );
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) r[w-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fftseq_agu.sv
// Butterfly address generator: operand pair (a, b) and twiddle index k
// for stage s, butterfly bf of an in-place radix-2 DIT FFT.
module fftseq_agu
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic [2:0]       s,
  input  logic [LOG2N-2:0] bf,
  output logic [LOG2N-1:0] a,
  output logic [LOG2N-1:0] b,
  output logic [LOG2N-1:0] k
);

  logic [LOG2N-1:0] bfx;
  logic [LOG2N-1:0] h;
  logic [LOG2N-1:0] j;

  always_comb begin
    bfx = {1'b0, bf};
    h   = LOG2N'(1) << s;
    j   = bfx & (h - LOG2N'(1));
    a   = ((bfx >> s) << (int'(s) + 1)) | j;
    b   = a + h;
    k   = j << (LOG2N - 1 - int'(s));
  end

endmodule

// File: rtl/fftseq.sv
// In-place radix-2 DIT FFT sequencer: FSM, stage/butterfly counters, registered controls.
// FFTSEQ_BITREV_LOAD_EN adds a bit-reversed sample load phase ahead of stage 0.
module fftseq
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fft_start,
  input  logic             fft_abort,
  output logic             fft_busy,
  output logic             fft_done,
  output logic [2:0]       stage,
  output logic [LOG2N-1:0] regfft_addr,
  output logic             regfft_wren,
  output logic             regfft_insel,
  output logic             regfft_clear,
  output logic [LOG2N-1:0] cfft_addr,
  output logic             cm_en,
  output logic             comadd_en,
  output logic             cm_shift,
  output logic             addsubfft_en,
  output logic             addsubfft_sel,
  output logic             addsubfft_shift,
  output logic [LOG2N-1:0] rd_addr,
  output logic             rd_en
);

  localparam int N  = 1 << LOG2N;
  localparam int NH = N / 2;
  localparam int BW = LOG2N - 1;

  state_t           st, nst;
  logic [2:0]       s, ns;
  logic [BW-1:0]    bf, nbf;
  logic [LOG2N-1:0] na, nb, nk;
  logic             last_bf, last_s, xf;

  logic             busy_d, done_d, wren_d, insel_d;
  logic             cm_d, cadd_d, shf_d, as_en_d, as_sel_d, as_shf_d;
  logic [LOG2N-1:0] addr_d, cfft_d;

`ifdef FFTSEQ_BITREV_LOAD_EN
  logic [LOG2N-1:0] n, nn;
  logic [15:0]      brv;
  logic             last_n;
  logic             rd_en_d;
  logic [LOG2N-1:0] rd_addr_d;

  assign last_n = (n == LOG2N'(N - 1));
  assign brv    = bitrev(16'(nn), LOG2N);
`endif

  assign last_bf = (bf == BW'(NH - 1));
  assign last_s  = (s == 3'(LOG2N - 1));

  always_comb begin
    nst = st;
    ns  = s;
    nbf = bf;
`ifdef FFTSEQ_BITREV_LOAD_EN
    nn  = n;
`endif
    unique case (st)
      IDLE: begin
        if (fft_start) begin
`ifdef FFTSEQ_BITREV_LOAD_EN
          nst = LD_RD;
          nn  = '0;
`else
          nst = RDB;
`endif
        end
      end
`ifdef FFTSEQ_BITREV_LOAD_EN
      LD_RD: nst = LD_WR;
      LD_WR: begin
        if (last_n) begin
          nst = RDB;
          nn  = '0;
        end else begin
          nst = LD_RD;
          nn  = n + LOG2N'(1);
        end
      end
`endif
      RDB:  nst = MUL;
      MUL:  nst = CADD;
      CADD: nst = RDA;
      RDA:  nst = SUB;
      SUB:  nst = WRB;
      WRB:  nst = RDA2;
      RDA2: nst = ADD;
      ADD:  nst = WRA;
      WRA: begin
        if (!last_bf) begin
          nbf = bf + BW'(1);
          nst = RDB;
        end else if (!last_s) begin
          nbf = '0;
          ns  = s + 3'd1;
          nst = RDB;
        end else begin
          nbf = '0;
          ns  = '0;
          nst = DONE;
        end
      end
      DONE:    nst = IDLE;
      default: nst = IDLE;
    endcase
    // abort overrides everything, including a same-cycle start
    if (fft_abort) begin
      nst = IDLE;
      ns  = '0;
      nbf = '0;
`ifdef FFTSEQ_BITREV_LOAD_EN
      nn  = '0;
`endif
    end
  end

  fftseq_agu #(
    .LOG2N(LOG2N)
  ) u_agu (
    .s (ns),
    .bf(nbf),
    .a (na),
    .b (nb),
    .k (nk)
  );

  // Outputs are decoded from next state so they register in step with it.
  always_comb begin
    xf       = nst inside {RDB, MUL, CADD, RDA, SUB, WRB, RDA2, ADD, WRA};
    busy_d   = (nst != IDLE) && (nst != DONE);
    done_d   = (nst == DONE);
    insel_d  = !(nst inside {IDLE, LD_RD, LD_WR});
    cfft_d   = xf ? nk : '0;
    addr_d   = '0;
    wren_d   = 1'b0;
    cm_d     = 1'b0;
    cadd_d   = 1'b0;
    shf_d    = 1'b0;
    as_en_d  = 1'b0;
    as_sel_d = 1'b0;
    as_shf_d = 1'b0;
`ifdef FFTSEQ_BITREV_LOAD_EN
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
`endif
    unique case (nst)
`ifdef FFTSEQ_BITREV_LOAD_EN
      LD_RD: begin
        rd_en_d   = 1'b1;
        rd_addr_d = nn;
      end
      LD_WR: begin
        addr_d = brv[LOG2N-1:0];
        wren_d = 1'b1;
      end
`endif
      RDB:  addr_d = nb;
      MUL:  cm_d = 1'b1;
      CADD: begin
        cadd_d = 1'b1;
        shf_d  = 1'b1;
      end
      RDA:  addr_d = na;
      SUB: begin
        addr_d   = na;
        as_en_d  = 1'b1;
        as_sel_d = 1'b1;
        as_shf_d = 1'b1;
      end
      WRB: begin
        addr_d = nb;
        wren_d = 1'b1;
      end
      RDA2: addr_d = na;
      ADD: begin
        addr_d   = na;
        as_en_d  = 1'b1;
        as_shf_d = 1'b1;
      end
      WRA: begin
        addr_d = na;
        wren_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st              <= IDLE;
      s               <= '0;
      bf              <= '0;
      fft_busy        <= 1'b0;
      fft_done        <= 1'b0;
      stage           <= '0;
      regfft_addr     <= '0;
      regfft_wren     <= 1'b0;
      regfft_insel    <= 1'b0;
      cfft_addr       <= '0;
      cm_en           <= 1'b0;
      comadd_en       <= 1'b0;
      cm_shift        <= 1'b0;
      addsubfft_en    <= 1'b0;
      addsubfft_sel   <= 1'b0;
      addsubfft_shift <= 1'b0;
    end else begin
      st              <= nst;
      s               <= ns;
      bf              <= nbf;
      fft_busy        <= busy_d;
      fft_done        <= done_d;
      stage           <= ns;
      regfft_addr     <= addr_d;
      regfft_wren     <= wren_d;
      regfft_insel    <= insel_d;
      cfft_addr       <= cfft_d;
      cm_en           <= cm_d;
      comadd_en       <= cadd_d;
      cm_shift        <= shf_d;
      addsubfft_en    <= as_en_d;
      addsubfft_sel   <= as_sel_d;
      addsubfft_shift <= as_shf_d;
    end
  end

`ifdef FFTSEQ_BITREV_LOAD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n       <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      n       <= nn;
      rd_en   <= rd_en_d;
      rd_addr <= rd_addr_d;
    end
  end
`else
  assign rd_en   = 1'b0;
  assign rd_addr = '0;
`endif

  // the imaginary clear on load is handled inside the datapath
  assign regfft_clear = 1'b0;

endmodule
